seq4_stepper: RTL and testbench

Synthesizable four-phase state stepper that produces the encoded state sequence S0→S1→S2→S3 consumed by the downstream state-display/decode stage. It runs each state for a programmable dwell time and supports freezing the sequence (hold). It stops after S3 with a one-cycle completion pulse. This replaces the behavioural event-driven stepping with a clocked, resettable source.

---
 rtl/seq4_stepper.sv | 117 +++++++++++
 tb/tb_seq4_stepper.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq4_stepper.sv
// seq4_stepper: four-phase state stepper (S0..S3) with a programmable
// per-state dwell, hold/freeze, and a one-cycle completion pulse.
// A run visits S0, S1, S2 and S3 once, then returns to idle and raises done.
module seq4_stepper #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         st_code,
  output logic               st_valid,
  output logic               step,
  output logic               done,
  output logic               busy
);

  // Control FSM: idle waiting for start, or stepping through a run.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Encoded run states; the next state is always the code plus one.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } code_t;

  localparam logic [DWELL_W-1:0] CNT_ZERO = '0;
  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  fsm_t               fsm_q,   fsm_d;
  code_t              code_q,  code_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               step_q,  step_d;
  logic               done_q,  done_d;

  // Successor code in the S0 -> S3 order.
  function automatic code_t next_code(input code_t cur);
    logic [1:0] raw;
    raw = cur + 2'd1;
    return code_t'(raw);
  endfunction

  // State register; reset aborts any run at once without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      code_q  <= S0;
      cnt_q   <= CNT_ZERO;
      dwell_q <= CNT_ZERO;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: hold freezes everything, otherwise count down the
  // dwell, advance the code at zero, and leave the run after S3 expires.
  always_comb begin
    fsm_d   = fsm_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        code_d = S0;
        if (start) begin
          // Dwell is captured here; later changes to the input are ignored.
          fsm_d   = RUN;
          cnt_d   = dwell;
          dwell_d = dwell;
        end
      end
      RUN: begin
        if (hold) begin
          // Frozen cycle: no counting, no step, no done.
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (code_q != S3) begin
          code_d = next_code(code_q);
          cnt_d  = dwell_q;
          step_d = 1'b1;
        end else begin
          fsm_d  = IDLE;
          code_d = S0;
          done_d = 1'b1;
        end
      end
      default: begin
        fsm_d  = IDLE;
        code_d = S0;
      end
    endcase
  end

  // Outputs come straight from flops so downstream decode sees clean levels.
  assign st_code  = code_q;
  assign st_valid = (fsm_q == RUN);
  assign busy     = (fsm_q == RUN);
  assign step     = step_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq4_stepper.sv
// Directed bench for seq4_stepper: reset, basic/minimum-dwell runs, hold,
// ignored inputs, back-to-back start and asynchronous abort.
module tb_seq4_stepper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       hold;
  logic [3:0] dwell;
  logic [1:0] st_code;
  logic       st_valid;
  logic       step;
  logic       done;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Output vector layout: {st_code, st_valid, busy, step, done}
  localparam logic [5:0] IDLE_V = 6'b00_0_0_0_0;
  localparam logic [5:0] DONE_V = 6'b00_0_0_0_1;

  // Expected codes per cycle for the dwell=1 run with 3 held cycles in S1.
  logic [1:0] hold_codes [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                                  2'd2, 2'd2, 2'd3, 2'd3};

  seq4_stepper #(.DWELL_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hold     (hold),
    .dwell    (dwell),
    .st_code  (st_code),
    .st_valid (st_valid),
    .step     (step),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] run_vec(input logic [1:0] code, input logic stp);
    return {code, 1'b1, 1'b1, stp, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp_v);
    logic [5:0] obs;
    obs = {st_code, st_valid, busy, step, done};
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b (code,valid,busy,step,done)", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    dwell = 4'd0;

    // Reset held low under random input activity
    for (int i = 0; i < 8; i++) begin
      start = 1'($urandom);
      hold  = 1'($urandom);
      dwell = 4'($urandom);
      tick();
      chk("reset", IDLE_V);
    end
    start = 1'b0;
    hold  = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", IDLE_V);
    hold = 1'b1;
    tick();
    chk("hold_in_idle", IDLE_V);
    hold = 1'b0;
    $display("[TB] reset/idle checks done");

    // Basic run, dwell=2: each state 3 cycles, done in cycle 12
    dwell = 4'd2;
    start = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      tick();
      start = 1'b0;
      if (c < 12)       chk("basic_run", run_vec(2'(c / 3), (c == 3) || (c == 6) || (c == 9)));
      else if (c == 12) chk("basic_done", DONE_V);
      else              chk("basic_idle_after", IDLE_V);
    end
    $display("[TB] basic dwell=2 run done");

    // Minimum dwell: one cycle per state, step in 3 consecutive cycles
    dwell = 4'd0;
    start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      tick();
      start = 1'b0;
      if (c < 4)       chk("min_dwell_run", run_vec(2'(c), c >= 1));
      else if (c == 4) chk("min_dwell_done", DONE_V);
      else             chk("min_dwell_idle", IDLE_V);
    end
    $display("[TB] minimum dwell run done");

    // Hold for 3 cycles in S1 with dwell=1: S1 spans cycles 2..6
    dwell = 4'd1;
    start = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      tick();
      start = 1'b0;
      if (c < 11)       chk("hold_run", run_vec(hold_codes[c], (c == 2) || (c == 7) || (c == 9)));
      else if (c == 11) chk("hold_done", DONE_V);
      else              chk("hold_idle", IDLE_V);
      if (c == 2) hold = 1'b1;
      if (c == 5) hold = 1'b0;
    end
    $display("[TB] hold run done");

    // Ignored inputs: dwell 1->7 and start kept high mid-run; start in the
    // done cycle launches a new run with dwell=7, which is aborted in S2.
    dwell = 4'd1;
    start = 1'b1;
    for (int c = 0; c <= 26; c++) begin
      tick();
      if (c < 8)        chk("ignore_run", run_vec(2'(c / 2), (c == 2) || (c == 4) || (c == 6)));
      else if (c == 8)  chk("ignore_done", DONE_V);
      else if (c < 17)  chk("restart_s0", run_vec(2'd0, 1'b0));
      else if (c == 17) chk("restart_s1_step", run_vec(2'd1, 1'b1));
      else if (c < 25)  chk("restart_s1", run_vec(2'd1, 1'b0));
      else if (c == 25) chk("restart_s2_step", run_vec(2'd2, 1'b1));
      else              chk("restart_s2", run_vec(2'd2, 1'b0));
      if (c == 0) dwell = 4'd7;
      if (c == 9) start = 1'b0;
    end
    $display("[TB] ignored-input and back-to-back run done");

    // Asynchronous abort in the middle of S2
    #1 rst_n = 1'b0;
    #1 chk("abort_async", IDLE_V);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_done", IDLE_V);
    end
    $display("[TB] async abort done");

    // Normal run after abort
    dwell = 4'd0;
    start = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      tick();
      start = 1'b0;
      if (c < 4) chk("post_abort_run", run_vec(2'(c), c >= 1));
      else       chk("post_abort_done", DONE_V);
    end
    $display("[TB] post-abort run done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
